// File: rtl/outer_product_rc_vvm.sv
// Rate-coded outer-product engine. Sign-magnitude operands are turned into
// deterministic unary bitstreams against a shared counter. Each row/column
// pair is ANDed and counted up or down according to the product sign, so
// after 2^(2M) enabled cycles every accumulator holds the exact signed product.
module outer_product_rc_vvm #(
    parameter int BITWIDTH    = 4,
    parameter int ROWNUM      = 2,
    parameter int COLNUM      = 2,
    parameter int OUTBITWIDTH = 2 * BITWIDTH
) (
    input  logic                                 iClk,
    input  logic                                 iRstN,
    input  logic                                 iEn,
    input  logic                                 iClr,
    input  logic [ROWNUM*BITWIDTH-1:0]           iData0,
    input  logic [COLNUM*BITWIDTH-1:0]           iData1,
    output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData
);

    localparam int M      = BITWIDTH - 1;
    localparam int CW     = 2 * M;
    localparam int NACC   = ROWNUM * COLNUM;

    localparam logic [OUTBITWIDTH-1:0] ACC_ONE = OUTBITWIDTH'(1);

    logic [CW-1:0]          r_cnt;
    logic [OUTBITWIDTH-1:0] r_acc   [NACC];
    logic [OUTBITWIDTH-1:0] w_acc_d [NACC];
    logic [M-1:0]           w_cnt_lo;
    logic [M-1:0]           w_cnt_hi;
    logic [ROWNUM-1:0]      w_row_bit;
    logic [ROWNUM-1:0]      w_row_sign;
    logic [COLNUM-1:0]      w_col_bit;
    logic [COLNUM-1:0]      w_col_sign;

    assign w_cnt_lo = r_cnt[M-1:0];
    assign w_cnt_hi = r_cnt[CW-1:M];

    // Row streams use the low counter half, column streams the high half, so
    // every (lo, hi) pair is visited once per period and the AND counts mag0*mag1.
    always_comb begin
        w_row_bit  = '0;
        w_row_sign = '0;
        w_col_bit  = '0;
        w_col_sign = '0;
        for (int r = 0; r < ROWNUM; r++) begin
            w_row_bit[r]  = (iData0[r*BITWIDTH +: M] > w_cnt_lo);
            w_row_sign[r] = iData0[r*BITWIDTH + M];
        end
        for (int c = 0; c < COLNUM; c++) begin
            w_col_bit[c]  = (iData1[c*BITWIDTH +: M] > w_cnt_hi);
            w_col_sign[c] = iData1[c*BITWIDTH + M];
        end
    end

    // Next accumulator values: step up or down by one where the product bit is set.
    always_comb begin
        for (int i = 0; i < NACC; i++) begin
            w_acc_d[i] = r_acc[i];
        end
        for (int r = 0; r < ROWNUM; r++) begin
            for (int c = 0; c < COLNUM; c++) begin
                if (w_row_bit[r] && w_col_bit[c]) begin
                    if (w_row_sign[r] ^ w_col_sign[c]) begin
                        w_acc_d[r*COLNUM+c] = r_acc[r*COLNUM+c] - ACC_ONE;
                    end else begin
                        w_acc_d[r*COLNUM+c] = r_acc[r*COLNUM+c] + ACC_ONE;
                    end
                end
            end
        end
    end

    // Counter and accumulator state: clear beats enable, otherwise hold.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_cnt <= '0;
            for (int i = 0; i < NACC; i++) begin
                r_acc[i] <= '0;
            end
        end else if (iClr) begin
            r_cnt <= '0;
            for (int i = 0; i < NACC; i++) begin
                r_acc[i] <= '0;
            end
        end else if (iEn) begin
            r_cnt <= r_cnt + CW'(1);
            for (int i = 0; i < NACC; i++) begin
                r_acc[i] <= w_acc_d[i];
            end
        end
    end

    // Flatten the accumulator array onto the output bus.
    always_comb begin
        oData = '0;
        for (int i = 0; i < NACC; i++) begin
            oData[i*OUTBITWIDTH +: OUTBITWIDTH] = r_acc[i];
        end
    end

endmodule

// File: tb/tb_outer_product_rc_vvm.sv
// Directed bench for outer_product_rc_vvm with default parameters (4-bit
// sign-magnitude operands, 2x2 array of 8-bit accumulators).
module tb_outer_product_rc_vvm;

    logic        iClk;
    logic        iRstN;
    logic        iEn;
    logic        iClr;
    logic [7:0]  iData0;
    logic [7:0]  iData1;
    logic [31:0] oData;

    int n_vec;
    int n_err;

    outer_product_rc_vvm dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iClr   (iClr),
        .iData0 (iData0),
        .iData1 (iData1),
        .oData  (oData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [7:0] ent(input int i);
        return oData[i*8 +: 8];
    endfunction

    // Enabled edges starting from a negedge; returns on the negedge after the last one.
    task automatic run_en(input int n);
        iEn = 1'b1;
        repeat (n) @(posedge iClk);
        @(negedge iClk);
        iEn = 1'b0;
    endtask

    task automatic do_clr();
        iClr = 1'b1;
        @(negedge iClk);
        iClr = 1'b0;
    endtask

    task automatic test_reset();
        iRstN  = 1'b0;
        iEn    = $urandom_range(0, 1);
        iClr   = 1'b0;
        iData0 = 8'($urandom);
        iData1 = 8'($urandom);
        repeat (3) @(negedge iClk);
        n_vec++;
        if (oData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", oData, 32'h0);
        end
        iEn = 1'b0;
        @(negedge iClk);
        iRstN = 1'b1;
        repeat (10) @(negedge iClk);
        n_vec++;
        if (oData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_idle: got %h want %h", oData, 32'h0);
        end
    endtask

    // Row {+2,-6}, column {-4,+4}: one period, then a second period without clear.
    task automatic test_basic();
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [4];
        exp1 = '{8'hF8, 8'h08, 8'h18, 8'hE8};
        exp2 = '{8'hF0, 8'h10, 8'h30, 8'hD0};
        iData0 = {4'b1110, 4'b0010};
        iData1 = {4'b0100, 4'b1100};
        do_clr();
        run_en(64);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ent(i) !== exp1[i]) begin
                n_err++;
                $display("FAIL basic_64[%0d]: got %h want %h", i, ent(i), exp1[i]);
            end
        end
        run_en(64);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ent(i) !== exp2[i]) begin
                n_err++;
                $display("FAIL basic_128[%0d]: got %h want %h", i, ent(i), exp2[i]);
            end
        end
    endtask

    task automatic test_max();
        iData0 = {4'b0111, 4'b0111};
        iData1 = {4'b1111, 4'b1111};
        do_clr();
        run_en(64);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ent(i) !== 8'hCF) begin
                n_err++;
                $display("FAIL max_mag[%0d]: got %h want %h", i, ent(i), 8'hCF);
            end
        end
    endtask

    // Row {-0,+5}, column {+3,-7}.
    task automatic test_negzero();
        logic [7:0] expv [4];
        expv = '{8'h00, 8'h00, 8'h0F, 8'hDD};
        iData0 = {4'b0101, 4'b1000};
        iData1 = {4'b1111, 4'b0011};
        do_clr();
        run_en(64);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ent(i) !== expv[i]) begin
                n_err++;
                $display("FAIL negzero[%0d]: got %h want %h", i, ent(i), expv[i]);
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] expv [4];
        expv = '{8'hF8, 8'h08, 8'h18, 8'hE8};
        iData0 = {4'b1110, 4'b0010};
        iData1 = {4'b0100, 4'b1100};
        do_clr();
        run_en(30);
        repeat (5) @(negedge iClk);
        run_en(34);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ent(i) !== expv[i]) begin
                n_err++;
                $display("FAIL pause[%0d]: got %h want %h", i, ent(i), expv[i]);
            end
        end
    endtask

    task automatic test_clr_en_and_async();
        logic [7:0] expv [4];
        expv = '{8'hF8, 8'h08, 8'h18, 8'hE8};
        iData0 = {4'b1110, 4'b0010};
        iData1 = {4'b0100, 4'b1100};
        run_en(20);
        iClr = 1'b1;
        iEn  = 1'b1;
        @(negedge iClk);
        iClr = 1'b0;
        iEn  = 1'b0;
        n_vec++;
        if (oData !== 32'h0) begin
            n_err++;
            $display("FAIL clr_en: got %h want %h", oData, 32'h0);
        end
        run_en(64);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ent(i) !== expv[i]) begin
                n_err++;
                $display("FAIL after_clr[%0d]: got %h want %h", i, ent(i), expv[i]);
            end
        end
        run_en(10);
        #2;
        iRstN = 1'b0;
        #1;
        n_vec++;
        if (oData !== 32'h0) begin
            n_err++;
            $display("FAIL async_rst: got %h want %h", oData, 32'h0);
        end
        @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);
        // Counter must also restart: a fresh period gives exact products.
        run_en(64);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ent(i) !== expv[i]) begin
                n_err++;
                $display("FAIL after_rst[%0d]: got %h want %h", i, ent(i), expv[i]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_max();
        test_negzero();
        test_pause();
        test_clr_en_and_async();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
